// File: rtl/vedic_mul_seq_ctrl_if.sv
// Handshake and shared-multiplier bus for the sequential vedic multiply controller.
// The controller is the slave; the requester is the master; the shared HALFxHALF multiplier uses mult.
interface vedic_mul_seq_ctrl_if #(
   parameter int HALF = 4
);
   logic                  start;
   logic [2*HALF-1:0]     a;
   logic [2*HALF-1:0]     b;
   logic                  busy;
   logic                  done;
   logic [4*HALF-1:0]     p;
   logic                  mul_en;
   logic [HALF-1:0]       mul_x;
   logic [HALF-1:0]       mul_y;
   logic [2*HALF-1:0]     mul_p;

   modport slave (
      input  start, a, b, mul_p,
      output busy, done, p, mul_en, mul_x, mul_y
   );

   modport master (
      output start, a, b,
      input  busy, done, p
   );

   modport mult (
      input  mul_en, mul_x, mul_y,
      output mul_p
   );
endinterface

// File: rtl/vedic_mul_seq_ctrl.sv
// Sequential 2*HALF x 2*HALF unsigned multiplier built from one shared HALFxHALF
// multiplier, summing four shifted partial products over states PP0..PP3.
module vedic_mul_seq_ctrl #(
   parameter int HALF = 4
) (
   input logic                 clk,
   input logic                 rst,
   vedic_mul_seq_ctrl_if.slave bus
);
   localparam int W  = 2 * HALF;
   localparam int PW = 4 * HALF;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PP0  = 3'd1,
      PP1  = 3'd2,
      PP2  = 3'd3,
      PP3  = 3'd4
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    a_reg, b_reg;
   logic [PW-1:0]   acc_reg, p_reg;
   logic            done_reg;

   logic [HALF-1:0] mul_x, mul_y;
   logic            busy;
   logic [PW-1:0]   pp_term;

   // Operand selection and partial-product weighting for the current phase.
   always_comb begin
      state_next = state_reg;
      mul_x      = '0;
      mul_y      = '0;
      busy       = 1'b0;
      pp_term    = '0;
      case (state_reg)
         IDLE: begin
            if (bus.start) state_next = PP0;
         end
         PP0: begin
            busy       = 1'b1;
            mul_x      = a_reg[HALF-1:0];
            mul_y      = b_reg[HALF-1:0];
            pp_term    = PW'(bus.mul_p);
            state_next = PP1;
         end
         PP1: begin
            busy       = 1'b1;
            mul_x      = a_reg[HALF-1:0];
            mul_y      = b_reg[W-1:HALF];
            pp_term    = PW'(bus.mul_p) << HALF;
            state_next = PP2;
         end
         PP2: begin
            busy       = 1'b1;
            mul_x      = a_reg[W-1:HALF];
            mul_y      = b_reg[HALF-1:0];
            pp_term    = PW'(bus.mul_p) << HALF;
            state_next = PP3;
         end
         PP3: begin
            busy       = 1'b1;
            mul_x      = a_reg[W-1:HALF];
            mul_y      = b_reg[W-1:HALF];
            pp_term    = PW'(bus.mul_p) << (2 * HALF);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         p_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_reg   <= bus.a;
                  b_reg   <= bus.b;
                  acc_reg <= '0;
               end
            end
            PP0, PP1, PP2: acc_reg <= acc_reg + pp_term;
            PP3: begin
               p_reg    <= acc_reg + pp_term;
               done_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy;
   assign bus.mul_en = busy;
   assign bus.mul_x  = mul_x;
   assign bus.mul_y  = mul_y;
   assign bus.done   = done_reg;
   assign bus.p      = p_reg;
endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Randomized self-checking bench for vedic_mul_seq_ctrl; products and operand
// sequences are predicted from plain arithmetic on the operands.
module tb_vedic_mul_seq_ctrl;
   logic clk;
   logic rst;

   vedic_mul_seq_ctrl_if #(.HALF(4)) bus ();

   vedic_mul_seq_ctrl #(.HALF(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural stand-in for the shared 4x4 multiplier.
   assign bus.mul_p = bus.mul_x * bus.mul_y;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_ops    = 0;
   int          n_done   = 0;
   logic [15:0] prev_p   = '0;

   always @(negedge clk) if (bus.done === 1'b1) n_done++;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Caller is 1 time unit after an edge; leaves the bench in the done cycle.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit inject);
      logic [15:0] expp;
      logic [3:0]  xs[4];
      logic [3:0]  ys[4];
      expp = {8'h00, av} * {8'h00, bv};
      xs   = '{av[3:0], av[3:0], av[7:4], av[7:4]};
      ys   = '{bv[3:0], bv[7:4], bv[3:0], bv[7:4]};
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
         if (inject && k == 1) begin
            bus.start = 1'b1;
            bus.a     = 8'hFF;
            bus.b     = 8'hFF;
         end
         if (inject && k == 2) bus.start = 1'b0;
         check_val("busy_pp",   32'(bus.busy),   32'd1);
         check_val("mul_en_pp", 32'(bus.mul_en), 32'd1);
         check_val("done_pp",   32'(bus.done),   32'd0);
         check_val("mul_x_pp",  32'(bus.mul_x),  32'(xs[k]));
         check_val("mul_y_pp",  32'(bus.mul_y),  32'(ys[k]));
         check_val("p_hold",    32'(bus.p),      32'(prev_p));
         @(posedge clk); #1;
      end
      check_val("done_pulse", 32'(bus.done),   32'd1);
      check_val("busy_done",  32'(bus.busy),   32'd0);
      check_val("mul_en_off", 32'(bus.mul_en), 32'd0);
      check_val("product",    32'(bus.p),      32'(expp));
      $display("op %0d: a=%02h b=%02h p=%04h expected=%04h inject=%0d",
               n_ops, av, bv, bus.p, expp, inject);
      prev_p = expp;
      n_ops++;
   endtask

   task automatic idle_step();
      bus.start = 1'b0;
      @(posedge clk); #1;
      check_val("done_clear", 32'(bus.done), 32'd0);
      check_val("busy_idle",  32'(bus.busy), 32'd0);
      check_val("p_idle",     32'(bus.p),    32'(prev_p));
   endtask

   initial begin
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #1 rst = 1'b1;
      #1;
      check_val("rst_busy",   32'(bus.busy),   32'd0);
      check_val("rst_done",   32'(bus.done),   32'd0);
      check_val("rst_p",      32'(bus.p),      32'd0);
      check_val("rst_mul_en", 32'(bus.mul_en), 32'd0);
      check_val("rst_mul_x",  32'(bus.mul_x),  32'd0);
      check_val("rst_mul_y",  32'(bus.mul_y),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      run_op(8'h0C, 8'h0A, 1'b0); idle_step();
      run_op(8'hFF, 8'hFF, 1'b0); idle_step();
      run_op(8'h00, 8'hB7, 1'b0); idle_step();
      run_op(8'h12, 8'h34, 1'b1); idle_step(); idle_step();
      run_op(8'h77, 8'h11, 1'b0);
      run_op(8'h80, 8'h02, 1'b0); idle_step();

      // Abort a multiply in PP2 with an asynchronous reset.
      bus.start = 1'b1;
      bus.a     = 8'h5A;
      bus.b     = 8'h3C;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_val("arst_busy",   32'(bus.busy),   32'd0);
      check_val("arst_mul_en", 32'(bus.mul_en), 32'd0);
      check_val("arst_mul_x",  32'(bus.mul_x),  32'd0);
      check_val("arst_mul_y",  32'(bus.mul_y),  32'd0);
      check_val("arst_done",   32'(bus.done),   32'd0);
      check_val("arst_p",      32'(bus.p),      32'd0);
      prev_p = '0;
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      idle_step(); idle_step();
      run_op(8'h03, 8'h05, 1'b0); idle_step();

      for (int i = 0; i < 20; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_step();
      end
      idle_step();

      check_val("done_count", 32'(n_done), 32'(n_ops));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
